// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input between successive
// gate ticks, publishes the binary count and then a packed-BCD copy produced
// by a sequential shift-add-3 converter.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   gate_tick    one-cycle pulse ending one window and starting the next
//   sig_in       asynchronous signal under measurement
//   count_out    edges counted in the last complete window
//   overflow     last complete window saturated
//   count_valid  one-cycle pulse when count_out/overflow update
//   bcd_out      packed BCD of count_out, most significant digit on top
//   bcd_busy     conversion in progress
//   bcd_valid    one-cycle pulse when bcd_out updates
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int BCD_DIGITS  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    gate_tick,
  input  logic                    sig_in,
  output logic [CNT_W-1:0]        count_out,
  output logic                    overflow,
  output logic                    count_valid,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_busy,
  output logic                    bcd_valid
);

  localparam int BW  = 4 * BCD_DIGITS;
  localparam int BCW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Input synchroniser plus previous-value flop for edge detection.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Window counter. An edge seen in the tick cycle opens the new window.
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      armed_q     <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else if (gate_tick) begin
      cnt_q       <= edge_det ? CNT_W'(1) : '0;
      sat_q       <= 1'b0;
      armed_q     <= 1'b1;
      // The window closed by the first tick after reset is partial.
      count_valid <= armed_q;
      if (armed_q) begin
        count_out <= cnt_q;
        overflow  <= sat_q;
      end
    end else begin
      count_valid <= 1'b0;
      if (edge_det && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_MAX - 1'b1) sat_q <= 1'b1;
      end
    end
  end

  // BCD conversion FSM.
  state_t           state_q, state_d;
  logic [BW-1:0]    acc_q, adj, bcd_q;
  logic [CNT_W-1:0] sh_q;
  logic [BCW-1:0]   bit_q;
  logic             done_ok;

  always_comb begin
    adj = acc_q;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      SHIFT:   if (bit_q == BCW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new count restarts conversion from any state.
    if (count_valid) state_d = SHIFT;
    // A restart arriving in DONE suppresses the publish of the old value.
    done_ok = (state_q == DONE) && !count_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (count_valid) begin
        sh_q  <= count_out;
        acc_q <= '0;
        bit_q <= BCW'(CNT_W);
      end else if (state_q == SHIFT) begin
        {acc_q, sh_q} <= {adj, sh_q} << 1;
        bit_q         <= bit_q - 1'b1;
      end
      if (done_ok) bcd_q <= acc_q;
    end
  end

  assign bcd_busy  = (state_q == SHIFT);
  assign bcd_valid = done_ok;
  assign bcd_out   = done_ok ? acc_q : bcd_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter. Two instances share the
// stimulus: the default 16-bit/5-digit build and a 4-bit/2-digit build that
// exercises saturation. Expected counts are queued when windows are driven;
// each count_valid pops one and arms an expected BCD result with its due cycle.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        reset, gate_tick, sig_in;

  logic [15:0] cnt_b;
  logic        ov_b, cv_b, busy_b, bv_b;
  logic [19:0] bcd_b;
  logic [3:0]  cnt_s;
  logic        ov_s, cv_s, busy_s, bv_s;
  logic [7:0]  bcd_s;

  freq_meter #(.CNT_W(16), .BCD_DIGITS(5), .SYNC_STAGES(2)) dut_big (
    .clk(clk), .reset(reset), .gate_tick(gate_tick), .sig_in(sig_in),
    .count_out(cnt_b), .overflow(ov_b), .count_valid(cv_b),
    .bcd_out(bcd_b), .bcd_busy(busy_b), .bcd_valid(bv_b));

  freq_meter #(.CNT_W(4), .BCD_DIGITS(2), .SYNC_STAGES(2)) dut_small (
    .clk(clk), .reset(reset), .gate_tick(gate_tick), .sig_in(sig_in),
    .count_out(cnt_s), .overflow(ov_s), .count_valid(cv_s),
    .bcd_out(bcd_s), .bcd_busy(busy_s), .bcd_valid(bv_s));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          exp0[$];
  int          exp1[$];
  bit          pend_v[2];
  int          pend_val[2];
  int          pend_due[2];
  logic [31:0] prev_bcd[2];
  logic        rst_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int to_bcd(input int n, input int digits);
    int r = 0;
    int v = n;
    for (int i = 0; i < digits; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Queue the expected result of one window of n edges for both builds.
  function automatic void push(input int n);
    exp0.push_back(n);
    exp1.push_back(((n >= 15) ? 32'h10000 : 0) | ((n > 15) ? 15 : n));
  endfunction

  task automatic mon(input int id, input logic cv, input logic [31:0] cnt,
                     input logic ov, input logic bv, input logic [31:0] bcd);
    int e;
    int w   = (id == 0) ? 16 : 4;
    int nd  = (id == 0) ? 5 : 2;
    int sz  = (id == 0) ? exp0.size() : exp1.size();
    if (bv) begin
      check("bcd_valid_expected", {31'b0, pend_v[id]}, 1);
      if (pend_v[id]) begin
        check("bcd_latency", cyc, pend_due[id]);
        check("bcd_value", bcd, pend_val[id]);
        pend_v[id] = 1'b0;
      end
    end else if (!rst_seen && bcd !== prev_bcd[id]) begin
      check("bcd_hold", bcd, prev_bcd[id]);
    end
    if (pend_v[id] && cyc > pend_due[id]) begin
      check("bcd_missing", 0, 1);
      pend_v[id] = 1'b0;
    end
    if (cv) begin
      if (sz == 0) begin
        check("count_valid_unexpected", 1, 0);
      end else begin
        if (id == 0) e = exp0.pop_front();
        else         e = exp1.pop_front();
        check("count", cnt, e & 32'hffff);
        check("overflow", {31'b0, ov}, (e >> 16) & 1);
        pend_v[id]   = 1'b1;
        pend_val[id] = to_bcd(e & 32'hffff, nd);
        pend_due[id] = cyc + w + 1;
      end
    end
    if (rst_seen) pend_v[id] = 1'b0;
    prev_bcd[id] = bcd;
  endtask

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    cyc++;
    mon(0, cv_b, {16'b0, cnt_b}, ov_b, bv_b, {12'b0, bcd_b});
    mon(1, cv_s, {28'b0, cnt_s}, ov_s, bv_s, {24'b0, bcd_s});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n, input int hi, input int lo);
    repeat (n) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  task automatic tick();
    repeat (4) step();
    gate_tick = 1'b1;
    step();
    gate_tick = 1'b0;
  endtask

  // Tick sampled in exactly the cycle the synchronised edge is detected.
  task automatic tick_edge();
    sig_in = 1'b1;
    step();
    step();
    gate_tick = 1'b1;
    step();
    gate_tick = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_cv();
    int n = 0;
    while (!cv_b && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("count_valid_timeout", 0, 1);
  endtask

  initial begin
    prev_bcd[0] = '0;
    prev_bcd[1] = '0;
    reset = 1'b1;
    gate_tick = 1'b0;
    sig_in = 1'b0;

    repeat (3) begin
      step();
      sig_in = ~sig_in;
      check("rst_count", {16'b0, cnt_b}, 0);
      check("rst_flags", {26'b0, ov_b, cv_b, busy_b, bv_b, ov_s, cv_s}, 0);
      check("rst_bcd", {12'b0, bcd_b}, 0);
      check("rst_small", {16'b0, busy_s, bv_s, bcd_s, 2'b0, cnt_s}, 0);
    end
    reset = 1'b0;
    sig_in = 1'b0;
    repeat (4) step();

    tick();                 // arms only
    push(0);
    tick();
    edges(37, 3, 3);
    push(37);
    tick();
    repeat (25) step();

    edges(20, 3, 3);
    push(20);
    tick();
    repeat (25) step();
    edges(3, 3, 3);
    push(3);
    tick();
    repeat (25) step();

    edges(5, 3, 3);
    push(5);
    tick_edge();
    edges(4, 3, 3);
    push(5);
    tick();
    repeat (25) step();

    sig_in = 1'b1;
    repeat (100) step();
    sig_in = 1'b0;
    repeat (3) step();
    push(1);
    tick();
    repeat (25) step();

    edges(2, 3, 3);
    push(2);
    push(0);
    repeat (4) step();
    gate_tick = 1'b1;
    step();
    step();
    gate_tick = 1'b0;
    repeat (25) step();

    edges(12345, 2, 2);
    push(12345);
    tick();
    wait_cv();
    push(0);
    tick();                 // lands mid-conversion on the wide build
    repeat (25) step();
    edges(9, 3, 3);
    push(9);
    tick();
    repeat (25) step();

    edges(7, 3, 3);
    push(7);
    tick();
    wait_cv();
    repeat (3) step();
    check("busy_before_reset", {30'b0, busy_b, busy_s}, 3);
    reset = 1'b1;
    step();
    check("reset_busy", {30'b0, busy_b, busy_s}, 0);
    check("reset_bcd", {4'b0, bcd_s, bcd_b}, 0);
    reset = 1'b0;
    repeat (20) step();

    tick();                 // re-arm after reset, no result
    edges(6, 3, 3);
    push(6);
    tick();
    repeat (25) step();

    check("queue_big_empty", exp0.size(), 0);
    check("queue_small_empty", exp1.size(), 0);
    check("bcd_pending_none", {30'b0, pend_v[0], pend_v[1]}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
